// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver: shadows a packed digit word, scans one
// anode per slot with a dead gap, decodes to active-low segments with blanking and blink.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 4,
  parameter int BLINK_HALF  = 25000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blink_en,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_DEAD = PRE_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  logic [4*NUM_DIGITS-1:0] digits_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   blink_sh;
  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        index;
  logic [BLK_W-1:0]        blink_cnt;
  logic                    blink_phase;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    lz_acc;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blink;
  logic                    cur_lz;
  logic                    digit_blank;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  // F is rendered as a dash rather than the letter
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0111111;
    endcase
    return g;
  endfunction

  // lz_mask[k]: digit k and everything above it are zero; digit 0 never qualifies
  always_comb begin
    lz_mask = '0;
    lz_acc  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_acc     = lz_acc & (digits_sh[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_acc;
    end
    lz_mask[0] = 1'b0;
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (index == IDX_W'(k)) begin
        cur_nib   = digits_sh[4*k +: 4];
        cur_dp    = dp_sh[k];
        cur_blink = blink_sh[k];
        cur_lz    = lz_mask[k];
      end
    end
  end

  always_comb begin
    an_nxt      = '1;
    seg_nxt     = 7'h7F;
    dp_nxt      = 1'b1;
    digit_blank = (cur_blink & blink_phase) | (blank_lz & cur_lz);
    if (presc >= PRE_DEAD) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_nxt[k] = (index != IDX_W'(k));
      end
      if (!digit_blank) begin
        seg_nxt = glyph(cur_nib);
        dp_nxt  = ~cur_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_sh   <= '0;
      dp_sh       <= '0;
      blink_sh    <= '0;
      presc       <= '0;
      index       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      an          <= '1;
    end else begin
      if (load) begin
        digits_sh <= digits_in;
        dp_sh     <= dp_in;
        blink_sh  <= blink_en;
      end

      if (presc == PRE_LAST) begin
        presc <= '0;
        index <= (index == IDX_LAST) ? '0 : index + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      seg <= seg_nxt;
      dp  <= dp_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count reference model queues the
// expected {an,seg,dp} each edge; scenario tasks pop and compare, plus glyph spot checks.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int DC = 1;
  localparam int BH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blink_en = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_q[$];
  logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h3F};

  int          mc = 0;
  logic [15:0] m_dig = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  m_blk = 4'h0;

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DC),
    .BLINK_HALF (BH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .digits_in(digits_in),
    .dp_in    (dp_in),
    .blink_en (blink_en),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  // Reference model: slot/prescaler/blink phase all derived from cycles since reset
  always @(posedge clk) begin : model
    logic [11:0] e;
    logic [3:0]  nib;
    logic [3:0]  a;
    logic        ph;
    logic        blank;
    int          slot;
    int          pre;
    if (rst) begin
      e     = {4'hF, 7'h7F, 1'b1};
      mc    = 0;
      m_dig = 16'h0;
      m_dp  = 4'h0;
      m_blk = 4'h0;
    end else begin
      pre  = mc % RD;
      slot = (mc / RD) % ND;
      ph   = ((mc / BH) % 2) == 1;
      if (pre < DC) begin
        e = {4'hF, 7'h7F, 1'b1};
      end else begin
        nib   = 4'(m_dig >> (4 * slot));
        blank = (m_blk[slot] && ph) || (blank_lz && slot != 0 && (m_dig >> (4 * slot)) == 16'h0);
        a     = ~(4'b0001 << slot);
        e     = blank ? {a, 7'h7F, 1'b1} : {a, glyph_tab[nib], ~m_dp[slot]};
      end
      mc++;
      if (load) begin
        m_dig = digits_in;
        m_dp  = dp_in;
        m_blk = blink_en;
      end
    end
    exp_q.push_back(e);
  end

  task automatic pop_exp(output logic [11:0] e, output bit ok);
    if (exp_q.size() == 0) begin
      e  = 12'hxxx;
      ok = 1'b0;
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [11:0] e, obs;
    bit ok;
    exp_q.delete();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pop_exp(e, ok);
      obs = {an, seg, dp};
      checks++;
      if (!ok || obs !== e) begin
        failures++;
        $display("FAIL reset_model cyc=%0d got=%h exp=%h", i, obs, e);
      end
      checks++;
      if (obs !== 12'hFFF) begin
        failures++;
        $display("FAIL reset_value cyc=%0d got=%h exp=fff", i, obs);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    pop_exp(e, ok);
    obs = {an, seg, dp};
    checks++;
    if (!ok || obs !== e || an !== 4'hF) begin
      failures++;
      $display("FAIL reset_first_dead got=%h exp=%h", obs, e);
    end
    @(negedge clk);
    pop_exp(e, ok);
    obs = {an, seg, dp};
    checks++;
    if (!ok || obs !== e || an !== 4'b1110 || seg !== 7'h40 || dp !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_active got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_scan();
    logic [11:0] e, obs;
    bit ok;
    int dead;
    logic [6:0] want;
    exp_q.delete();
    digits_in = 16'h1234;
    dp_in = 4'h0;
    blink_en = 4'h0;
    blank_lz = 1'b0;
    load = 1'b1;
    @(negedge clk);
    pop_exp(e, ok);
    load = 1'b0;
    dead = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      pop_exp(e, ok);
      obs = {an, seg, dp};
      checks++;
      if (!ok || obs !== e) begin
        failures++;
        $display("FAIL scan_model cyc=%0d got=%h exp=%h", i, obs, e);
      end
      case (an)
        4'b1110: want = 7'h19;
        4'b1101: want = 7'h30;
        4'b1011: want = 7'h24;
        4'b0111: want = 7'h79;
        default: want = 7'h7F;
      endcase
      if (an == 4'hF) dead++;
      checks++;
      if (seg !== want || (an != 4'hF && dp !== 1'b1)) begin
        failures++;
        $display("FAIL scan_glyph an=%b got=%h exp=%h dp=%b", an, seg, want, dp);
      end
    end
    checks++;
    if (dead != 8) begin
      failures++;
      $display("FAIL scan_dead_count got=%0d exp=8", dead);
    end
  endtask

  task automatic test_leading_zero();
    logic [11:0] e, obs;
    bit ok;
    int active_hi;
    exp_q.delete();
    digits_in = 16'h0007;
    blank_lz = 1'b1;
    load = 1'b1;
    @(negedge clk);
    pop_exp(e, ok);
    load = 1'b0;
    active_hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pop_exp(e, ok);
      obs = {an, seg, dp};
      checks++;
      if (!ok || obs !== e) begin
        failures++;
        $display("FAIL lz_model cyc=%0d got=%h exp=%h", i, obs, e);
      end
      if (an != 4'hF && an != 4'b1110) active_hi++;
      checks++;
      if ((an == 4'b1110 && seg !== 7'h78) || (an != 4'b1110 && (seg !== 7'h7F || dp !== 1'b1))) begin
        failures++;
        $display("FAIL lz_glyph an=%b got=%h", an, seg);
      end
    end
    checks++;
    if (active_hi != 9) begin
      failures++;
      $display("FAIL lz_anodes_driven got=%0d exp=9", active_hi);
    end
    digits_in = 16'h0000;
    load = 1'b1;
    @(negedge clk);
    pop_exp(e, ok);
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pop_exp(e, ok);
      obs = {an, seg, dp};
      checks++;
      if (!ok || obs !== e || (an == 4'b1110 && seg !== 7'h40) || (an != 4'b1110 && seg !== 7'h7F)) begin
        failures++;
        $display("FAIL lz_all_zero cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_blink();
    logic [11:0] e, obs;
    bit ok;
    int vis, blk;
    exp_q.delete();
    digits_in = 16'h5555;
    blink_en = 4'b0001;
    load = 1'b1;
    @(negedge clk);
    pop_exp(e, ok);
    load = 1'b0;
    vis = 0;
    blk = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      pop_exp(e, ok);
      obs = {an, seg, dp};
      checks++;
      if (!ok || obs !== e) begin
        failures++;
        $display("FAIL blink_model cyc=%0d got=%h exp=%h", i, obs, e);
      end
      if (an == 4'b1110) begin
        if (seg === 7'h12) vis++;
        else if (seg === 7'h7F) blk++;
      end else if (an != 4'hF) begin
        checks++;
        if (seg !== 7'h12) begin
          failures++;
          $display("FAIL blink_steady an=%b got=%h exp=12", an, seg);
        end
      end
    end
    checks++;
    if (vis == 0 || blk == 0 || vis + blk != 24) begin
      failures++;
      $display("FAIL blink_phases vis=%0d blank=%0d exp both nonzero sum 24", vis, blk);
    end
    blink_en = 4'h0;
  endtask

  task automatic test_codes();
    logic [11:0] e, obs;
    bit ok;
    logic [7:0] want;
    logic [15:0] words [2];
    logic [3:0]  dps [2];
    words[0] = 16'hFEDC;
    dps[0]   = 4'b0100;
    words[1] = 16'hBA98;
    dps[1]   = 4'b0000;
    for (int w = 0; w < 2; w++) begin
      exp_q.delete();
      digits_in = words[w];
      dp_in = dps[w];
      load = 1'b1;
      @(negedge clk);
      pop_exp(e, ok);
      load = 1'b0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        pop_exp(e, ok);
        obs = {an, seg, dp};
        checks++;
        if (!ok || obs !== e) begin
          failures++;
          $display("FAIL codes_model w=%0d cyc=%0d got=%h exp=%h", w, i, obs, e);
        end
        if (w == 0) begin
          case (an)
            4'b1110: want = {7'h46, 1'b1};
            4'b1101: want = {7'h21, 1'b1};
            4'b1011: want = {7'h06, 1'b0};
            4'b0111: want = {7'h3F, 1'b1};
            default: want = {7'h7F, 1'b1};
          endcase
        end else begin
          case (an)
            4'b1110: want = {7'h00, 1'b1};
            4'b1101: want = {7'h10, 1'b1};
            4'b1011: want = {7'h08, 1'b1};
            4'b0111: want = {7'h03, 1'b1};
            default: want = {7'h7F, 1'b1};
          endcase
        end
        checks++;
        if ({seg, dp} !== want) begin
          failures++;
          $display("FAIL codes_glyph w=%0d an=%b got=%h exp=%h", w, an, {seg, dp}, want);
        end
      end
    end
    dp_in = 4'h0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] e, obs;
    bit ok;
    bit found;
    logic [3:0] prev_an;
    exp_q.delete();
    digits_in = 16'h1111;
    load = 1'b1;
    @(negedge clk);
    pop_exp(e, ok);
    load = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 5) begin
        digits_in = 16'h2222;
        load = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      pop_exp(e, ok);
      obs = {an, seg, dp};
      checks++;
      if (!ok || obs !== e || (an != 4'hF && seg !== 7'h79 && seg !== 7'h24)) begin
        failures++;
        $display("FAIL b2b_glyph cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
    found = 1'b0;
    prev_an = an;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      pop_exp(e, ok);
      if (prev_an == 4'hF && an != 4'hF) found = 1'b1;
      prev_an = an;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL b2b_wait_active got=timeout exp=active slot");
    end
    digits_in = 16'h3333;
    rst = 1'b1;
    load = 1'b1;
    @(negedge clk);
    pop_exp(e, ok);
    obs = {an, seg, dp};
    checks++;
    if (!ok || obs !== e || obs !== 12'hFFF) begin
      failures++;
      $display("FAIL b2b_midslot_reset got=%h exp=fff", obs);
    end
    rst = 1'b0;
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pop_exp(e, ok);
      obs = {an, seg, dp};
      checks++;
      if (!ok || obs !== e || (an == 4'b1110 && seg !== 7'h40)) begin
        failures++;
        $display("FAIL b2b_rst_wins cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_scan();
    test_leading_zero();
    test_blink();
    test_codes();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
